track_tx_formatter: RTL and testbench

TRACK_TX_FORMATTER -- requirements
Module: track_tx_formatter

---
 rtl/emtf_tx_pkg.sv | 80 ++++++++
 rtl/track_tx_formatter_if.sv | 19 +
 rtl/tx_rate_counter.sv | 25 ++
 rtl/track_tx_formatter.sv | 103 ++++++++++
 tb/tb_track_tx_formatter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/emtf_tx_pkg.sv
// Shared definitions for the EMTF track transmit formatter.
// Covers field widths, word bit offsets, qcode encodings and the per-track field decoder.
package emtf_tx_pkg;

    localparam int PT_W    = 9;
    localparam int QLT_W   = 4;
    localparam int ETA_W   = 9;
    localparam int PHI_W   = 8;
    localparam int QCODE_W = 4;
    localparam int ADDR_W  = 16;
    localparam int WORD_W  = 64;

    localparam int PT_LSB      = 0;
    localparam int QUAL_LSB    = 9;
    localparam int ETA_LSB     = 13;
    localparam int PHI_LSB     = 23;
    localparam int SPEC_LO_BIT = 31;
    localparam int CHG_BIT     = 32;
    localparam int CHGV_BIT    = 33;
    localparam int ID_LSB      = 34;
    localparam int SPEC_HI_BIT = 63;

    localparam logic [QCODE_W-1:0] QCODE_NONE   = 4'd0;
    localparam logic [QCODE_W-1:0] QCODE_SINGLE = 4'd1;
    localparam logic [QLT_W-1:0]   SINGLE_NOCHG_QLT = 4'd10;
    localparam logic [PT_W-1:0]    SINGLE_PT_BASE   = 9'd10;
    localparam int                 BX_MAX_DEFAULT   = 3563;

    typedef struct packed {
        logic [PT_W-1:0]  pt;
        logic [QLT_W-1:0] qual;
        logic             chg;
        logic             chg_v;
    } trk_fields_t;

    function automatic trk_fields_t decode_track(
        input logic [QCODE_W-1:0] qcode,
        input logic [QLT_W-1:0]   qlt,
        input logic [PT_W-1:0]    pt,
        input logic [ETA_W-1:0]   eta,
        input logic               crg,
        input logic               endcap
    );
        trk_fields_t      f;
        logic [ETA_W-1:0] abs_eta;
        f       = '{pt: pt, qual: qlt, chg: crg, chg_v: 1'b1};
        abs_eta = endcap ? ~eta : eta;
        if (qcode == QCODE_NONE) begin
            f.pt = '0;
        end else if (qcode == QCODE_SINGLE) begin
            // Single-LCT tracks carry no measured pT; it is estimated from the coarse |eta| bin.
            f.chg_v = (qlt != SINGLE_NOCHG_QLT);
            f.chg   = (qlt == SINGLE_NOCHG_QLT) ? 1'b0 : (qlt[0] ^ endcap);
            f.qual  = {2'b00, qlt[3:2]};
            f.pt    = SINGLE_PT_BASE - PT_W'(abs_eta[8:5]);
        end
        return f;
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(
        input trk_fields_t       f,
        input logic [ETA_W-1:0]  eta,
        input logic [PHI_W-1:0]  phi,
        input logic [10:0]       bx11,
        input logic [1:0]        idx,
        input logic [ADDR_W-1:0] addr
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[PT_LSB +: PT_W]    = f.pt;
        w[QUAL_LSB +: QLT_W] = f.qual;
        w[ETA_LSB +: ETA_W]  = eta;
        w[PHI_LSB +: PHI_W]  = phi;
        w[CHG_BIT]           = f.chg;
        w[CHGV_BIT]          = f.chg_v;
        w[ID_LSB +: 29]      = {bx11, idx, addr};
        return w;
    endfunction

endpackage

// File: rtl/track_tx_formatter_if.sv
// Per-track input bundle and formatted link outputs of the track transmit formatter.
interface track_tx_formatter_if
    import emtf_tx_pkg::*;
#(
    parameter int NTRK = 3
);
    logic [NTRK-1:0][PT_W-1:0]    pt;
    logic [NTRK-1:0][QLT_W-1:0]   qlt;
    logic [NTRK-1:0][ETA_W-1:0]   eta;
    logic [NTRK-1:0][PHI_W-1:0]   phi;
    logic [NTRK-1:0]              crg;
    logic [NTRK-1:0][QCODE_W-1:0] qcode;
    logic [NTRK-1:0][ADDR_W-1:0]  trk_addr;
    logic [NTRK-1:0][WORD_W-1:0]  txdata;
    logic [NTRK-1:0][PT_W-1:0]    pt_tx;

    modport master (output pt, qlt, eta, phi, crg, qcode, trk_addr, input txdata, pt_tx);
    modport slave  (input pt, qlt, eta, phi, crg, qcode, trk_addr, output txdata, pt_tx);
endinterface

// File: rtl/tx_rate_counter.sv
// Saturating per-track event counter with a periodic latch-and-clear into the rate output.
module tx_rate_counter #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         latch,
    output logic [W-1:0] rate
);
    logic [W-1:0] cnt;

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            rate <= '0;
        end else if (latch) begin
            rate <= cnt;
            cnt  <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/track_tx_formatter.sv
// Formats NTRK track candidates into 64-bit link words with BX/sync side bits,
// hard-reset blanking, a test pattern mode and per-track rate monitoring.
module track_tx_formatter
    import emtf_tx_pkg::*;
#(
    parameter int NTRK   = 3,
    parameter int RATE_W = 26,
    parameter int HR_W   = 24,
    parameter int BX_MAX = BX_MAX_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    track_tx_formatter_if.slave         trk,
    input  logic                        bc0,
    input  logic                        hard_reset,
    input  logic [HR_W-1:0]             hr_to,
    input  logic                        endcap,
    input  logic                        test_mode,
    input  logic [NTRK-1:0]             trk_mask,
    input  logic [RATE_W-1:0]           rate_period,
    output logic [NTRK-1:0][RATE_W-1:0] track_rate,
    output logic                        sync_err
);
    localparam int TEST_W = 30;

    logic [11:0]                 bxn;
    logic [HR_W-1:0]             hr_cnt;
    logic [15:0]                 pat_cnt;
    logic [RATE_W-1:0]           per_cnt;
    logic                        hr_active;
    logic                        rate_latch;
    logic [3:0]                  spec_lo;
    logic [3:0]                  spec_hi;
    logic [NTRK-1:0]             rate_inc;
    logic [NTRK-1:0][WORD_W-1:0] word_nxt;
    logic [NTRK-1:0][PT_W-1:0]   pt_nxt;
    trk_fields_t                 fld;

    assign hr_active = (hr_cnt != '0);
    // >= rather than == so a rate_period lowered below the running count latches at the next compare.
    assign rate_latch = (per_cnt >= rate_period);
    assign spec_lo    = {1'b0, bxn[2], bxn[0], bc0};
    assign spec_hi    = {2'b00, bxn[1], sync_err};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        word_nxt = '0;
        pt_nxt   = '0;
        rate_inc = '0;
        fld      = '0;
        for (int i = 0; i < NTRK; i++) begin
            fld       = decode_track(trk.qcode[i], trk.qlt[i], trk.pt[i], trk.eta[i],
                                     trk.crg[i], endcap);
            pt_nxt[i] = fld.pt;
            if (test_mode) begin
                word_nxt[i][TEST_W-1:0] = {bxn, 2'(i), pat_cnt};
            end else if (!(hr_active || trk_mask[i])) begin
                word_nxt[i] = pack_word(fld, trk.eta[i], trk.phi[i], bxn[10:0], 2'(i),
                                        trk.trk_addr[i]);
            end
            // Side-channel bits stay live through blanking, masking and test mode.
            word_nxt[i][SPEC_LO_BIT] = spec_lo[i];
            word_nxt[i][SPEC_HI_BIT] = spec_hi[i];
            rate_inc[i] = (trk.qcode[i] != QCODE_NONE) && !hr_active && !trk_mask[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk.txdata <= '0;
            trk.pt_tx  <= '0;
            bxn        <= '0;
            sync_err   <= 1'b0;
            hr_cnt     <= '0;
            pat_cnt    <= '0;
            per_cnt    <= '0;
        end else begin
            trk.txdata <= word_nxt;
            trk.pt_tx  <= pt_nxt;
            bxn        <= bc0 ? 12'd0 : bxn + 12'd1;
            if (bc0 && (bxn != 12'(BX_MAX))) begin
                sync_err <= 1'b1;
            end
            if (hard_reset) begin
                hr_cnt <= hr_to;
            end else if (hr_active) begin
                hr_cnt <= hr_cnt - HR_W'(1);
            end
            pat_cnt <= pat_cnt + 16'd1;
            per_cnt <= rate_latch ? '0 : per_cnt + RATE_W'(1);
        end
    end

    for (genvar g = 0; g < NTRK; g++) begin : g_rate
        tx_rate_counter #(.W(RATE_W)) u_rate (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (rate_inc[g]),
            .latch (rate_latch),
            .rate  (track_rate[g])
        );
    end
endmodule

// File: tb/tb_track_tx_formatter.sv
// Self-checking bench for track_tx_formatter: decode table, corner sequences and a
// randomized run scored against a cycle-level arithmetic model.
module tb_track_tx_formatter;
    localparam int NTRK     = 3;
    localparam int RATE_W   = 8;
    localparam int HR_W     = 24;
    localparam int RATE_MAX = (1 << RATE_W) - 1;
    localparam logic [63:0] SPEC_BITS = 64'h8000_0000_8000_0000;

    logic                        clk;
    logic                        rst_n;
    logic                        bc0;
    logic                        hard_reset;
    logic [HR_W-1:0]             hr_to;
    logic                        endcap;
    logic                        test_mode;
    logic [NTRK-1:0]             trk_mask;
    logic [RATE_W-1:0]           rate_period;
    logic [NTRK-1:0][RATE_W-1:0] track_rate;
    logic                        sync_err;

    track_tx_formatter_if #(.NTRK(NTRK)) bus ();

    track_tx_formatter #(.NTRK(NTRK), .RATE_W(RATE_W), .HR_W(HR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trk         (bus),
        .bc0         (bc0),
        .hard_reset  (hard_reset),
        .hr_to       (hr_to),
        .endcap      (endcap),
        .test_mode   (test_mode),
        .trk_mask    (trk_mask),
        .rate_period (rate_period),
        .track_rate  (track_rate),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: plain integers advanced once per clock.
    int      m_bxn, m_pat, m_per;
    longint  m_hr;
    bit      m_sync;
    int      m_cnt  [NTRK];
    int      m_rate [NTRK];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_bxn = 0; m_pat = 0; m_per = 0; m_hr = 0; m_sync = 0;
        for (int i = 0; i < NTRK; i++) begin
            m_cnt[i]  = 0;
            m_rate[i] = 0;
        end
    endfunction

    function automatic void model_fields(input int i, output int ptv, output int q,
                                         output int chg, output int cv);
        int qc, ql, ab;
        qc  = int'(bus.qcode[i]);
        ql  = int'(bus.qlt[i]);
        ptv = int'(bus.pt[i]);
        q   = ql;
        chg = int'(bus.crg[i]);
        cv  = 1;
        if (qc == 0) begin
            ptv = 0;
        end else if (qc == 1) begin
            ab  = endcap ? 511 - int'(bus.eta[i]) : int'(bus.eta[i]);
            cv  = (ql != 10) ? 1 : 0;
            chg = (ql == 10) ? 0 : (endcap ? 1 - (ql % 2) : ql % 2);
            q   = ql / 4;
            ptv = (10 - ab / 32) & 511;
        end
    endfunction

    function automatic logic [63:0] fld64(input int v, input int sh);
        logic [63:0] x;
        x = 64'(v);
        return x << sh;
    endfunction

    function automatic logic [63:0] model_word(input int i);
        logic [63:0] w;
        int ptv, q, chg, cv;
        w = '0;
        if (test_mode) begin
            w = fld64(m_bxn, 18) | fld64(i, 16) | fld64(m_pat, 0);
        end else if (m_hr == 0 && !trk_mask[i]) begin
            model_fields(i, ptv, q, chg, cv);
            w = fld64(ptv, 0) | fld64(q, 9) | fld64(int'(bus.eta[i]), 13)
              | fld64(int'(bus.phi[i]), 23) | fld64(chg, 32) | fld64(cv, 33)
              | fld64(int'(bus.trk_addr[i]), 34) | fld64(i, 50) | fld64(m_bxn % 2048, 52);
        end
        case (i)
            0: begin w[31] = bc0;               w[63] = m_sync; end
            1: begin w[31] = 1'(m_bxn % 2);     w[63] = 1'((m_bxn / 2) % 2); end
            2: begin w[31] = 1'((m_bxn / 4) % 2); w[63] = 1'b0; end
            default: ;
        endcase
        return w;
    endfunction

    function automatic void model_advance();
        bit lat;
        lat = (m_per >= int'(rate_period));
        for (int i = 0; i < NTRK; i++) begin
            if (lat) begin
                m_rate[i] = m_cnt[i];
                m_cnt[i]  = 0;
            end else if (bus.qcode[i] != 0 && m_hr == 0 && !trk_mask[i] && m_cnt[i] < RATE_MAX) begin
                m_cnt[i]++;
            end
        end
        m_per = lat ? 0 : m_per + 1;
        if (bc0 && m_bxn != 3563) m_sync = 1;
        m_bxn = bc0 ? 0 : (m_bxn + 1) % 4096;
        m_hr  = hard_reset ? longint'(hr_to) : (m_hr > 0 ? m_hr - 1 : 0);
        m_pat = (m_pat + 1) % 65536;
    endfunction

    task automatic tick();
        logic [63:0] ew [NTRK];
        int          ep [NTRK];
        int          q, chg, cv;
        for (int i = 0; i < NTRK; i++) begin
            ew[i] = model_word(i);
            model_fields(i, ep[i], q, chg, cv);
        end
        model_advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < NTRK; i++) begin
            check($sformatf("txdata[%0d]", i), bus.txdata[i], ew[i]);
            check($sformatf("pt_tx[%0d]", i), 64'(bus.pt_tx[i]), 64'(ep[i]));
            check($sformatf("track_rate[%0d]", i), 64'(track_rate[i]), 64'(m_rate[i]));
        end
        check("sync_err", 64'(sync_err), 64'(m_sync));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < NTRK; i++) begin
            check($sformatf("rst txdata[%0d]", i), bus.txdata[i], 64'd0);
            check($sformatf("rst pt_tx[%0d]", i), 64'(bus.pt_tx[i]), 64'd0);
            check($sformatf("rst track_rate[%0d]", i), 64'(track_rate[i]), 64'd0);
        end
        check("rst sync_err", 64'(sync_err), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] qcode;
        logic [8:0] pt;
        logic [3:0] qlt;
        logic [8:0] eta;
        logic       crg;
        logic       endcap;
        logic [8:0] e_pt;
        logic [3:0] e_qual;
        logic       e_chg;
        logic       e_cv;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] p1;

    initial begin
        vecs[0] = '{4'd5,  9'd100, 4'd12, 9'h020, 1'b1, 1'b0, 9'd100, 4'd12, 1'b1, 1'b1};
        vecs[1] = '{4'd1,  9'd0,   4'd10, 9'h1BF, 1'b1, 1'b1, 9'd8,   4'd2,  1'b0, 1'b0};
        vecs[2] = '{4'd0,  9'd77,  4'd7,  9'h011, 1'b1, 1'b0, 9'd0,   4'd7,  1'b1, 1'b1};
        vecs[3] = '{4'd1,  9'd50,  4'd13, 9'd96,  1'b0, 1'b0, 9'd7,   4'd3,  1'b1, 1'b1};
        vecs[4] = '{4'd1,  9'd50,  4'd6,  9'h1FF, 1'b0, 1'b1, 9'd10,  4'd1,  1'b1, 1'b1};
        vecs[5] = '{4'd1,  9'd50,  4'd4,  9'h1E0, 1'b1, 1'b0, 9'h1FB, 4'd1,  1'b0, 1'b1};
        vecs[6] = '{4'd15, 9'd511, 4'd15, 9'h0AA, 1'b0, 1'b0, 9'd511, 4'd15, 1'b0, 1'b1};

        rst_n = 1'b1; bc0 = 1'b0; hard_reset = 1'b0; hr_to = '0; endcap = 1'b0;
        test_mode = 1'b0; trk_mask = '0; rate_period = 8'd9;
        bus.pt = '0; bus.qlt = '0; bus.eta = '0; bus.phi = '0; bus.crg = '0;
        bus.qcode = '0; bus.trk_addr = '0;
        bus.phi[0] = 8'h5A; bus.trk_addr[0] = 16'hBEEF; bus.trk_addr[1] = 16'h1234;
        @(posedge clk);
        #1;
        model_reset();
        do_reset();

        // Field decode table on track 0.
        for (int k = 0; k < 7; k++) begin
            bus.qcode[0] = vecs[k].qcode; bus.pt[0] = vecs[k].pt; bus.qlt[0] = vecs[k].qlt;
            bus.eta[0] = vecs[k].eta; bus.crg[0] = vecs[k].crg; endcap = vecs[k].endcap;
            tick();
            check($sformatf("vec%0d pt_tx", k), 64'(bus.pt_tx[0]), 64'(vecs[k].e_pt));
            check($sformatf("vec%0d quality", k), 64'(bus.txdata[0][12:9]), 64'(vecs[k].e_qual));
            check($sformatf("vec%0d charge", k), 64'(bus.txdata[0][32]), 64'(vecs[k].e_chg));
            check($sformatf("vec%0d chg_valid", k), 64'(bus.txdata[0][33]), 64'(vecs[k].e_cv));
        end

        // Masked link stays zero, then carries the test pattern.
        endcap = 1'b0; bus.qcode[0] = 4'd5; bus.pt[0] = 9'd100; bus.qlt[0] = 4'd12;
        bus.qcode[1] = 4'd5; bus.pt[1] = 9'd33; bus.qlt[1] = 4'd3;
        trk_mask = 3'b010;
        tick();
        check("mask link1 data", bus.txdata[1] & ~SPEC_BITS, 64'd0);
        test_mode = 1'b1;
        tick();
        p1 = bus.txdata[1][15:0];
        check("tm link1 index", 64'(bus.txdata[1][17:16]), 64'd1);
        tick();
        check("tm pattern step", 64'(bus.txdata[1][15:0]), 64'(p1 + 16'd1));
        test_mode = 1'b0; trk_mask = '0;
        tick();

        // Hard-reset blanking for hr_to cycles.
        hr_to = 24'd5; hard_reset = 1'b1;
        tick();
        hard_reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hr blank link0", bus.txdata[0] & ~SPEC_BITS, 64'd0);
            check("hr blank link1", bus.txdata[1] & ~SPEC_BITS, 64'd0);
        end
        tick();
        check("hr restored", 64'(|(bus.txdata[0] & ~SPEC_BITS)), 64'd1);

        // Rate monitor: period 9 gives 9 counts every 10 clocks, then full-scale.
        bus.qcode = '0; bus.qcode[0] = 4'd5; rate_period = 8'd9;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k % 10 == 0) check("rate period 9", 64'(track_rate[0]), 64'd9);
        end
        rate_period = 8'd255;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 256; k++) tick();
            check("rate full scale", 64'(track_rate[0]), 64'(RATE_MAX));
        end

        // Randomized run with a mid-period reset.
        rate_period = 8'd7;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NTRK; i++) begin
                bus.qcode[i] = ($urandom_range(0, 3) == 0) ? 4'd0 :
                               (($urandom_range(0, 2) == 0) ? 4'd1 : 4'($urandom));
                bus.pt[i] = 9'($urandom); bus.qlt[i] = 4'($urandom);
                bus.eta[i] = 9'($urandom); bus.phi[i] = 8'($urandom);
                bus.crg[i] = 1'($urandom); bus.trk_addr[i] = 16'($urandom);
            end
            endcap     = 1'($urandom);
            test_mode  = ($urandom_range(0, 15) == 0);
            trk_mask   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            hard_reset = ($urandom_range(0, 40) == 0);
            hr_to      = 24'($urandom_range(0, 7));
            bc0        = ($urandom_range(0, 50) == 0);
            if ($urandom_range(0, 30) == 0) rate_period = 8'($urandom_range(0, 20));
            if (c == 200) do_reset();
            tick();
        end

        // BX sync: bc0 on the last BX is fine, off-orbit bc0 is sticky.
        bc0 = 1'b0; hard_reset = 1'b0; test_mode = 1'b0; trk_mask = '0;
        do_reset();
        for (int k = 0; k < 3563; k++) tick();
        bc0 = 1'b1;
        tick();
        bc0 = 1'b0;
        check("sync ok at BX_MAX", 64'(sync_err), 64'd0);
        for (int k = 0; k < 100; k++) tick();
        bc0 = 1'b1;
        tick();
        bc0 = 1'b0;
        check("sync err at bxn 100", 64'(sync_err), 64'd1);
        for (int k = 0; k < 5; k++) tick();
        check("sync err sticky", 64'(sync_err), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
